fetch_q: RTL and testbench

FETCH_Q -- requirements
Module: fetch_q

---
 rtl/fetch_q.sv | 123 ++++++++++++
 tb/tb_fetch_q.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_q.sv
// Purpose : instruction prefetch queue; one outstanding memory read, DEPTH-entry buffer, branch flush.
// Latency : request issues combinationally in RUN; a push at edge N makes instr_valid visible in cycle N+1.
// Backpressure: no issue unless a free entry exists for the outstanding slot; instr_take pops the head.
//
// Ports:
//   clk, rst_f                 - clock, asynchronous active-high reset
//   br_taken, br_addr          - redirect pulse and its word-address target
//   mem_req, mem_addr          - read request to instruction memory (held until mem_ack)
//   mem_ack, mem_rdata         - read completion and instruction word
//   instr_valid, instr_out,
//   instr_pc, instr_take       - head of the prefetch buffer and consumer pop
module fetch_q #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        br_taken,
    input  logic [15:0] br_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [15:0] instr_pc,
    input  logic        instr_take
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,   // nothing outstanding
        ST_WAIT  = 2'd1,   // one request outstanding, data will be kept
        ST_DRAIN = 2'd2    // one request outstanding, data will be dropped
    } state_t;

    state_t        state_q, state_d;
    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q;
    logic [15:0]   fetch_pc_q;
    logic [15:0]   req_addr_q;   // address of the outstanding request
    logic          ack_q;        // an ack completed last cycle; keeps mem_req low for one cycle

    logic issue, push, pop;

    always_comb begin
        state_d = state_q;
        // Issuing in RUN never overflows: with nothing outstanding, count < DEPTH
        // guarantees a slot for the returning word. Reset gating keeps mem_req low
        // while rst_f is held even though the state already reads RUN.
        issue = (state_q == ST_RUN) && !rst_f && !ack_q && !br_taken && (count_q < FULL_CNT);
        push  = (state_q == ST_WAIT) && mem_ack && !br_taken;
        pop   = instr_take && (count_q != '0) && !br_taken;

        case (state_q)
            ST_RUN: begin
                if (issue) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack)       state_d = ST_RUN;
                else if (br_taken) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mem_ack) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= ST_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            ack_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_q != ST_RUN) && mem_ack;
            if (issue) req_addr_q <= fetch_pc_q;

            if (br_taken) begin
                // Flush wins over any coincident push or pop.
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= br_addr;
            end else begin
                if (push) begin
                    fifo_q[tail_q] <= '{instr: mem_rdata, pc: req_addr_q};
                    tail_q         <= tail_q + AW'(1);
                    fetch_pc_q     <= fetch_pc_q + 16'd1;
                end
                if (pop) head_q <= head_q + AW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + (AW+1)'(1);
                    2'b01:   count_q <= count_q - (AW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // While a request is outstanding fetch_pc may already hold a redirect target,
    // so the held request address drives the bus instead.
    assign mem_req     = issue || (state_q != ST_RUN);
    assign mem_addr    = (state_q == ST_RUN) ? fetch_pc_q : req_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_out   = fifo_q[head_q].instr;
    assign instr_pc    = fifo_q[head_q].pc;

endmodule

// File: tb/tb_fetch_q.sv
// Purpose : randomized scoreboard bench for fetch_q; the bench plays the instruction memory.
// Latency : memory acks 1..4 cycles after a request; expected words are queued at ack time.
// Backpressure: consumer pops at a random rate; the monitor checks the head every cycle.
module tb_fetch_q;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        br_taken = 1'b0;
    logic [15:0] br_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_take = 1'b0;

    fetch_q #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_take  (instr_take)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
    } exp_t;

    // Reference model: the instruction stream is simply consecutive addresses from
    // the last redirect; a word is kept only if no redirect hit its request.
    exp_t        sb[$];
    logic [15:0] exp_pc = RST_PC;
    bit          outstanding = 1'b0;
    bit          stale = 1'b0;
    bit          prev_ack = 1'b0;
    int          wait_cnt = 0;
    logic [15:0] out_addr = '0;

    int checks = 0;
    int failures = 0;
    int issues = 0;

    int          br_pct = 0, take_pct = 0, lat_max = 0;
    bit          force_br = 1'b0, force_take = 1'b0, force_ack = 1'b0, rel_rst = 1'b0;
    logic [15:0] force_br_addr = '0;

    function automatic logic [31:0] rdata_of(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then at +2 observe the
    // request side and advance the model to the state after the coming rising edge.
    task automatic step();
        bit br, ack;
        @(negedge clk);
        if (rel_rst) begin
            rst_f   = 1'b0;
            rel_rst = 1'b0;
        end
        br  = force_br || ($urandom_range(99) < br_pct);
        ack = force_ack || (outstanding && wait_cnt == 0);
        if (outstanding && wait_cnt > 0) wait_cnt--;
        br_taken   = br;
        br_addr    = force_br ? force_br_addr : 16'($urandom);
        instr_take = force_take || ($urandom_range(99) < take_pct);
        mem_ack    = ack;
        mem_rdata  = ack ? rdata_of(out_addr) : $urandom;
        force_br = 1'b0; force_take = 1'b0; force_ack = 1'b0;
        #2;
        if (prev_ack) chk("req_low_after_ack", mem_req, 1'b0);
        prev_ack = ack && outstanding;
        if (outstanding) begin
            chk("req_hold", {mem_req, mem_addr}, {1'b1, out_addr});
            if (ack) begin
                outstanding = 1'b0;
                if (!stale && !br) begin
                    sb.push_back('{instr: rdata_of(exp_pc), pc: exp_pc});
                    exp_pc = exp_pc + 16'd1;
                end
            end
        end else if (mem_req) begin
            chk("issue_addr", mem_addr, exp_pc);
            chk("no_issue_on_flush", br, 1'b0);
            issues++;
            outstanding = 1'b1;
            stale       = 1'b0;
            out_addr    = mem_addr;
            wait_cnt    = $urandom_range(lat_max, 0);
        end
        if (br) begin
            if (outstanding) stale = 1'b1;
            sb.delete();
            exp_pc = br_addr;
        end
    endtask

    // Monitor: compares the presented head against the scoreboard every cycle and
    // retires the entry when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_f) begin
                chk("instr_valid", instr_valid, sb.size() != 0);
                if (instr_valid && sb.size() != 0) begin
                    chk("head", {instr_out, instr_pc}, {sb[0].instr, sb[0].pc});
                    if (instr_take && !br_taken) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int  n;
        bit  found;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, RST_PC);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_instr_pc", instr_pc, 16'h0);

        // Streaming with no consumer: four fetches across the 16-bit wrap, then stall.
        br_pct = 0; take_pct = 0; lat_max = 0;
        rel_rst = 1'b1;
        step();
        chk("first_issue_after_release", issues, 1);
        repeat (20) step();
        chk("stream_issue_count", issues, 4);
        chk("full_no_req", mem_req, 1'b0);
        chk("full_head_pc", instr_pc, RST_PC);

        // Single pop while full: exactly one refill request.
        n = issues;
        force_take = 1'b1;
        step();
        repeat (12) step();
        chk("refill_one_issue", issues - n, 1);
        chk("refill_full_no_req", mem_req, 1'b0);
        chk("refill_head_pc", instr_pc, 16'hFFFF);

        // Random traffic: flushes land in every state, including on ack cycles.
        br_pct = 8; take_pct = 50; lat_max = 3;
        repeat (3000) step();

        // Build three buffered entries plus a pending request, then reset mid-flight.
        br_pct = 0; take_pct = 0;
        force_br = 1'b1; force_br_addr = 16'h0100;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (sb.size() == 3 && outstanding) found = 1'b1;
        end
        chk("prefill_reached", found, 1'b1);

        @(negedge clk);
        rst_f = 1'b1; br_taken = 1'b0; instr_take = 1'b0; mem_ack = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_instr_valid", instr_valid, 1'b0);
        chk("midrst_mem_addr", mem_addr, RST_PC);
        sb.delete();
        outstanding = 1'b0; stale = 1'b0; prev_ack = 1'b0;
        exp_pc = RST_PC;
        repeat (2) @(negedge clk);

        // Stray ack in the first cycle after release must be ignored.
        n = issues;
        rel_rst = 1'b1; force_ack = 1'b1; lat_max = 1;
        step();
        chk("refetch_after_reset", issues - n, 1);

        br_pct = 8; take_pct = 50; lat_max = 3;
        repeat (500) step();
        br_pct = 0; take_pct = 100;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
